// File: rtl/iiitb_bcd_updown_counter.sv
// iiitb_bcd_updown_counter: multi-digit BCD up/down counter with wrap/saturate bounds, load and sticky flags
module iiitb_bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  sat_mode,
    input  logic [4*DIGITS-1:0]   max_val,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  clr_flags,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};
    logic [W-1:0] inc_val, dec_val, max_eff, next_val;
    logic [3:0] d;
    logic cin, bin, max_bad, load_bad, load_ok, at_top, at_zero, hit;
    // Decimal ripple increment/decrement, digit validity and the effective upper bound
    always_comb begin
        inc_val = count;
        dec_val = count;
        cin = 1'b1;
        bin = 1'b1;
        max_bad = 1'b0;
        load_bad = 1'b0;
        d = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            d = count[4*k +: 4];
            inc_val[4*k +: 4] = cin ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
            dec_val[4*k +: 4] = bin ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
            cin = cin & (d == 4'd9);
            bin = bin & (d == 4'd0);
            max_bad = max_bad | (max_val[4*k +: 4] > 4'd9);
            load_bad = load_bad | (load_val[4*k +: 4] > 4'd9);
        end
        max_eff = max_bad ? ALL9 : max_val;
        load_ok = !load_bad && (load_val <= max_eff);
        at_top = count >= max_eff;
        at_zero = count == '0;
        hit = en && (up_dn ? at_top : at_zero);
        next_val = up_dn ? (at_top ? (sat_mode ? count : '0) : inc_val)
                         : (at_zero ? (sat_mode ? count : max_eff) : dec_val);
    end
    // Count, boundary pulse and sticky flags; reset beats load beats enable
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count <= '0;
            tc <= 1'b0;
            ovf <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (load) count <= load_ok ? load_val : count;
            else if (en) count <= next_val;
            tc <= !load && hit;
            ovf <= (!load && hit) || (ovf && !clr_flags);
            load_err <= (load && !load_ok) || (load_err && !clr_flags);
        end
    end
endmodule
